// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state encoding,
// timed-out load data and word-alignment helpers.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  localparam logic [31:0] BadDataDefault = 32'hDEADBEEF;
  localparam logic [1:0]  WordAlignMask  = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & WordAlignMask) != 2'b00;
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return addr & ~{30'b0, WordAlignMask};
  endfunction

endpackage

// File: rtl/mem_access_stage_bus_fsm.sv
// Data-memory bus sequencer: state register, timeout counter, registered bus
// request outputs, captured read data and one-cycle error pulses.
module mem_access_stage_bus_fsm
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] BAD_DATA       = BadDataDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memop,
  input  logic        misaligned,
  input  logic        wmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output mem_state_e  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] rdata_q,
  output logic        align_err,
  output logic        bus_err
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
      tmo_cnt   <= '0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      // Error flags are pulses: cleared every cycle unless re-raised below.
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (memop) begin
            if (misaligned) begin
              align_err <= 1'b1;
            end else begin
              mem_addr  <= word_addr(addr);
              mem_wdata <= wdata;
              mem_we    <= wmem;
              mem_req   <= 1'b1;
              tmo_cnt   <= '0;
              state     <= StBusy;
            end
          end
        end
        StBusy: begin
          // Ack takes priority over a coinciding timeout.
          if (mem_ack) begin
            rdata_q <= mem_we ? 32'h0 : mem_rdata;
            mem_req <= 1'b0;
            state   <= StDone;
          end else if (tmo_cnt == TmoLast) begin
            rdata_q <= BAD_DATA;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= StDone;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores on the data bus, stalls the front
// end while an access is outstanding and feeds MEM/WB (bubble while stalled).
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] BAD_DATA       = BadDataDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validin,
  input  logic        wregin,
  input  logic        m2regin,
  input  logic        wmemin,
  input  logic [4:0]  RdRtin,
  input  logic [31:0] aluresultin,
  input  logic [31:0] storedatain,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wregout,
  output logic        m2regout,
  output logic [4:0]  RdRtout,
  output logic [31:0] aluresultout,
  output logic [31:0] memdataout,
  output logic        align_err,
  output logic        bus_err
);

  mem_state_e  state;
  logic [31:0] rdata_q;
  logic        memop;
  logic        misaligned;

  assign memop      = validin & (m2regin | wmemin);
  assign misaligned = is_misaligned(aluresultin);

  mem_access_stage_bus_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .BAD_DATA       (BAD_DATA)
  ) u_bus_fsm (
    .clk        (clk),
    .rst        (rst),
    .memop      (memop),
    .misaligned (misaligned),
    .wmem       (wmemin),
    .addr       (aluresultin),
    .wdata      (storedatain),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .state      (state),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .rdata_q    (rdata_q),
    .align_err  (align_err),
    .bus_err    (bus_err)
  );

  always_comb begin
    stall        = 1'b0;
    wregout      = 1'b0;
    m2regout     = 1'b0;
    RdRtout      = '0;
    aluresultout = '0;
    memdataout   = '0;
    unique case (state)
      StIdle: begin
        if (validin && !memop) begin
          wregout      = wregin;
          RdRtout      = RdRtin;
          aluresultout = aluresultin;
        end else if (memop && !misaligned) begin
          stall = 1'b1;
        end
      end
      StBusy: stall = 1'b1;
      // EX/MEM was frozen by the stall, so its inputs still describe this access.
      StDone: begin
        if (validin) begin
          wregout      = wregin;
          m2regout     = m2regin & ~wmemin;
          RdRtout      = RdRtin;
          aluresultout = aluresultin;
          memdataout   = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus random
// operations checked against a transaction-level reference model.
module tb_mem_access_stage;

  localparam int          Tmo     = 16;
  localparam logic [31:0] BadData = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        validin, wregin, m2regin, wmemin;
  logic [4:0]  RdRtin;
  logic [31:0] aluresultin, storedatain;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wregout, m2regout;
  logic [4:0]  RdRtout;
  logic [31:0] aluresultout, memdataout;
  logic        align_err, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk          (clk),
    .rst          (rst),
    .validin      (validin),
    .wregin       (wregin),
    .m2regin      (m2regin),
    .wmemin       (wmemin),
    .RdRtin       (RdRtin),
    .aluresultin  (aluresultin),
    .storedatain  (storedatain),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .wregout      (wregout),
    .m2regout     (m2regout),
    .RdRtout      (RdRtout),
    .aluresultout (aluresultout),
    .memdataout   (memdataout),
    .align_err    (align_err),
    .bus_err      (bus_err)
  );

  // ack_delay: BUSY cycle (1-based) on which mem_ack pulses; 0 or > Tmo means never.
  typedef struct {
    logic        valid, wreg, m2reg, wmem;
    logic [4:0]  rd;
    logic [31:0] alu, sdata, rdata;
    int          ack_delay;
  } op_t;

  typedef struct {
    int          stall_cycles, req_cycles, align_cnt, bus_cnt;
    logic        we;
    logic [31:0] addr, wdata;
    logic        wreg, m2reg;
    logic [4:0]  rd;
    logic [31:0] alu, mdata;
    bit          hung;
  } res_t;

  // Reference model: whole-transaction outcome from the stage's rules.
  function automatic res_t model(input op_t op);
    res_t r;
    bit   memop, timed_out;
    int   busy;
    r = '{default: 0};
    memop = op.valid && (op.m2reg || op.wmem);
    if (!op.valid) return r;
    if (!memop) begin
      r.wreg = op.wreg; r.rd = op.rd; r.alu = op.alu;
      return r;
    end
    if (op.alu % 4 != 0) begin
      r.align_cnt = 1;
      return r;
    end
    timed_out      = !(op.ack_delay >= 1 && op.ack_delay <= Tmo);
    busy           = timed_out ? Tmo : op.ack_delay;
    r.stall_cycles = busy + 1;
    r.req_cycles   = busy;
    r.we           = op.wmem;
    r.addr         = op.alu - (op.alu % 4);
    r.wdata        = op.sdata;
    r.wreg         = op.wreg;
    r.m2reg        = op.m2reg && !op.wmem;
    r.rd           = op.rd;
    r.alu          = op.alu;
    r.mdata        = timed_out ? BadData : (op.wmem ? 32'h0 : op.rdata);
    r.bus_cnt      = timed_out ? 1 : 0;
    return r;
  endfunction

  // Drives one op from IDLE and observes it until stall drops, plus two idle cycles.
  // Entered and left just after a rising edge.
  task automatic do_op(input op_t op, output res_t o);
    int cyc;
    bit seen_req;
    o = '{default: 0};
    seen_req    = 0;
    validin     = op.valid;
    wregin      = op.wreg;
    m2regin     = op.m2reg;
    wmemin      = op.wmem;
    RdRtin      = op.rd;
    aluresultin = op.alu;
    storedatain = op.sdata;
    mem_rdata   = op.rdata;
    mem_ack     = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        o.req_cycles++;
        if (!seen_req) begin
          o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata; seen_req = 1;
        end
      end
      if (align_err !== 1'b0) o.align_cnt++;
      if (bus_err !== 1'b0) o.bus_cnt++;
      if (stall !== 1'b1) begin
        o.wreg = wregout; o.m2reg = m2regout; o.rd = RdRtout;
        o.alu = aluresultout; o.mdata = memdataout;
        break;
      end
      o.stall_cycles++;
      if (cyc >= 40) begin
        o.hung = 1;
        break;
      end
      mem_ack = (cyc != 0 && cyc == op.ack_delay);
      cyc++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    @(posedge clk); #1;
    validin = 1'b0;
    mem_ack = 1'b0;
    if (o.hung) rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (!o.hung) begin
        if (align_err !== 1'b0) o.align_cnt++;
        if (bus_err !== 1'b0) o.bus_cnt++;
        if (mem_req !== 1'b0) o.req_cycles++;
      end
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; validin = 1'b0; wregin = 1'b1; m2regin = 1'b1; wmemin = 1'b1;
    RdRtin = 5'd3; aluresultin = 32'h100; storedatain = 32'hFFFF_0000;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++;
      $display("FAIL reset_bus_ctl got req=%b we=%b exp 0 0", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++;
      $display("FAIL reset_bus_data got addr=%h wdata=%h exp 0 0", mem_addr, mem_wdata); end
    checks++; if (align_err !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL reset_flags got align=%b bus=%b stall=%b exp 0 0 0", align_err, bus_err,
               stall); end
    checks++; if ({wregout, m2regout, RdRtout, aluresultout, memdataout} !== '0) begin errors++;
      $display("FAIL reset_bubble got wreg=%b m2reg=%b rd=%0d alu=%h mdata=%h exp all 0",
               wregout, m2regout, RdRtout, aluresultout, memdataout); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_passthrough();
    op_t op; res_t o;
    op = '{valid: 1, wreg: 1, m2reg: 0, wmem: 0, rd: 5'd5, alu: 32'h10, sdata: 32'h77,
           rdata: 32'h0, ack_delay: 0};
    do_op(op, o);
    checks++; if (o.wreg !== 1'b1 || o.rd !== 5'd5 || o.alu !== 32'h10) begin errors++;
      $display("FAIL alu_pass got wreg=%b rd=%0d alu=%h exp 1 5 10", o.wreg, o.rd, o.alu); end
    checks++; if (o.mdata !== 32'h0 || o.stall_cycles != 0 || o.req_cycles != 0) begin errors++;
      $display("FAIL alu_nomem got mdata=%h stall=%0d req=%0d exp 0 0 0", o.mdata,
               o.stall_cycles, o.req_cycles); end
  endtask

  task automatic test_load();
    op_t op; res_t o;
    op = '{valid: 1, wreg: 1, m2reg: 1, wmem: 0, rd: 5'd7, alu: 32'h40, sdata: 32'h0,
           rdata: 32'hCAFEF00D, ack_delay: 3};
    do_op(op, o);
    checks++; if (o.req_cycles != 3 || o.stall_cycles != 4) begin errors++;
      $display("FAIL load_timing got req=%0d stall=%0d exp 3 4", o.req_cycles,
               o.stall_cycles); end
    checks++; if (o.we !== 1'b0 || o.addr !== 32'h40) begin errors++;
      $display("FAIL load_bus got we=%b addr=%h exp 0 40", o.we, o.addr); end
    checks++; if (o.m2reg !== 1'b1 || o.mdata !== 32'hCAFEF00D || o.wreg !== 1'b1) begin
      errors++;
      $display("FAIL load_done got m2reg=%b mdata=%h wreg=%b exp 1 cafef00d 1", o.m2reg,
               o.mdata, o.wreg); end
  endtask

  task automatic test_store();
    op_t op; res_t o;
    op = '{valid: 1, wreg: 0, m2reg: 0, wmem: 1, rd: 5'd0, alu: 32'h44, sdata: 32'h12345678,
           rdata: 32'hAAAA5555, ack_delay: 1};
    do_op(op, o);
    checks++; if (o.we !== 1'b1 || o.wdata !== 32'h12345678 || o.addr !== 32'h44) begin
      errors++;
      $display("FAIL store_bus got we=%b wdata=%h addr=%h exp 1 12345678 44", o.we, o.wdata,
               o.addr); end
    checks++; if (o.stall_cycles != 2 || o.bus_cnt != 0 || o.m2reg !== 1'b0) begin errors++;
      $display("FAIL store_done got stall=%0d buserr=%0d m2reg=%b exp 2 0 0", o.stall_cycles,
               o.bus_cnt, o.m2reg); end
  endtask

  task automatic test_misaligned();
    op_t op; res_t o;
    op = '{valid: 1, wreg: 1, m2reg: 1, wmem: 0, rd: 5'd9, alu: 32'h42, sdata: 32'h0,
           rdata: 32'h0, ack_delay: 1};
    do_op(op, o);
    checks++; if (o.req_cycles != 0 || o.stall_cycles != 0) begin errors++;
      $display("FAIL misalign_noreq got req=%0d stall=%0d exp 0 0", o.req_cycles,
               o.stall_cycles); end
    checks++; if (o.align_cnt != 1 || o.wreg !== 1'b0) begin errors++;
      $display("FAIL misalign_err got alignpulses=%0d wreg=%b exp 1 0", o.align_cnt, o.wreg); end
  endtask

  task automatic test_timeout();
    op_t op; res_t o;
    op = '{valid: 1, wreg: 1, m2reg: 1, wmem: 0, rd: 5'd2, alu: 32'h80, sdata: 32'h0,
           rdata: 32'h13579BDF, ack_delay: 0};
    do_op(op, o);
    checks++; if (o.bus_cnt != 1 || o.mdata !== BadData) begin errors++;
      $display("FAIL timeout_err got buspulses=%0d mdata=%h exp 1 deadbeef", o.bus_cnt,
               o.mdata); end
    checks++; if (o.stall_cycles != Tmo + 1 || o.req_cycles != Tmo) begin errors++;
      $display("FAIL timeout_len got stall=%0d req=%0d exp %0d %0d", o.stall_cycles,
               o.req_cycles, Tmo + 1, Tmo); end
    // Ack on the last allowed BUSY cycle beats the timeout.
    op.ack_delay = Tmo;
    do_op(op, o);
    checks++; if (o.bus_cnt != 0 || o.mdata !== 32'h13579BDF) begin errors++;
      $display("FAIL ack_vs_timeout got buspulses=%0d mdata=%h exp 0 13579bdf", o.bus_cnt,
               o.mdata); end
  endtask

  task automatic test_reset_mid_access();
    op_t op; res_t o;
    validin = 1'b1; wregin = 1'b1; m2regin = 1'b1; wmemin = 1'b0; RdRtin = 5'd9;
    aluresultin = 32'h80; storedatain = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++;
      $display("FAIL midrst_busy got req=%b exp 1", mem_req); end
    @(posedge clk); #1;
    rst = 1'b0; validin = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL midrst_drop got req=%b stall=%b exp 0 0", mem_req, stall); end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || align_err !== 1'b0 || bus_err !== 1'b0 ||
                  memdataout !== 32'h0 || wregout !== 1'b0) begin errors++;
      $display("FAIL midrst_lateack got req=%b align=%b bus=%b mdata=%h wreg=%b exp 0 0 0 0 0",
               mem_req, align_err, bus_err, memdataout, wregout); end
    @(posedge clk); #1;
    // A fresh load must see a full issue/busy/done sequence, proving the FSM sat in IDLE.
    op = '{valid: 1, wreg: 1, m2reg: 1, wmem: 0, rd: 5'd4, alu: 32'hC0, sdata: 32'h0,
           rdata: 32'h0BADF00D, ack_delay: 2};
    do_op(op, o);
    checks++; if (o.stall_cycles != 3 || o.mdata !== 32'h0BADF00D) begin errors++;
      $display("FAIL midrst_recover got stall=%0d mdata=%h exp 3 0badf00d", o.stall_cycles,
               o.mdata); end
  endtask

  task automatic test_random();
    op_t op; res_t o, e;
    for (int i = 0; i < 40; i++) begin
      op.valid = ($urandom_range(0, 7) != 0);
      op.wreg  = 1'($urandom_range(0, 1));
      op.m2reg = 1'($urandom_range(0, 1));
      op.wmem  = 1'($urandom_range(0, 2) == 0);
      op.rd    = 5'($urandom);
      op.alu   = $urandom;
      if ($urandom_range(0, 3) != 0) op.alu[1:0] = 2'b00;
      op.sdata = $urandom;
      op.rdata = $urandom;
      op.ack_delay = ($urandom_range(0, 5) == 0) ? $urandom_range(0, Tmo + 2)
                                                 : $urandom_range(1, 4);
      e = model(op);
      do_op(op, o);
      checks++; if (o.hung) begin errors++;
        $display("FAIL rand[%0d] hang got stall stuck exp release", i); end
      checks++; if (o.stall_cycles != e.stall_cycles || o.req_cycles != e.req_cycles) begin
        errors++;
        $display("FAIL rand[%0d] timing got stall=%0d req=%0d exp %0d %0d", i, o.stall_cycles,
                 o.req_cycles, e.stall_cycles, e.req_cycles); end
      checks++; if (o.align_cnt != e.align_cnt || o.bus_cnt != e.bus_cnt) begin errors++;
        $display("FAIL rand[%0d] errs got align=%0d bus=%0d exp %0d %0d", i, o.align_cnt,
                 o.bus_cnt, e.align_cnt, e.bus_cnt); end
      checks++; if (o.wreg !== e.wreg || o.m2reg !== e.m2reg || o.rd !== e.rd) begin errors++;
        $display("FAIL rand[%0d] ctl got wreg=%b m2reg=%b rd=%0d exp %b %b %0d", i, o.wreg,
                 o.m2reg, o.rd, e.wreg, e.m2reg, e.rd); end
      checks++; if (o.alu !== e.alu || o.mdata !== e.mdata) begin errors++;
        $display("FAIL rand[%0d] data got alu=%h mdata=%h exp %h %h", i, o.alu, o.mdata,
                 e.alu, e.mdata); end
      if (e.req_cycles > 0) begin
        checks++; if (o.we !== e.we || o.addr !== e.addr || o.wdata !== e.wdata) begin errors++;
          $display("FAIL rand[%0d] bus got we=%b addr=%h wdata=%h exp %b %h %h", i, o.we,
                   o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish exp finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alu_passthrough();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
